// File: rtl/rv_regfile_drdw_if.sv
// Register file port bundle: two write ports, two read ports.
// from_rf is the register file side; to_rf is the pipeline side.
interface rf_drdw_intf #(
    parameter int addr_w = 4,
    parameter int data_w = 32
);
    logic [addr_w-1:0] Rd1Addr;
    logic [data_w-1:0] Rd1Data;
    logic [addr_w-1:0] Rd2Addr;
    logic [data_w-1:0] Rd2Data;
    logic [addr_w-1:0] Rs1Addr;
    logic [addr_w-1:0] Rs2Addr;
    logic [data_w-1:0] Rs1Data;
    logic [data_w-1:0] Rs2Data;

    modport from_rf (
        input  Rd1Addr, Rd1Data,
        input  Rd2Addr, Rd2Data,
        input  Rs1Addr, Rs2Addr,
        output Rs1Data, Rs2Data
    );

    modport to_rf (
        output Rd1Addr, Rd1Data,
        output Rd2Addr, Rd2Data,
        output Rs1Addr, Rs2Addr,
        input  Rs1Data, Rs2Data
    );
endinterface

// File: rtl/rv_regfile_drdw.sv
// Dual-read dual-write register file, x0 hardwired to zero.
// Port 2 is the younger instruction: it wins collisions and forwarding.
module rv_regfile_drdw #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    rf_drdw_intf.from_rf rf
);
    localparam int NREG = (1 << ADDR_W) - 1;

    logic [DATA_W-1:0] regs [1:NREG];
    logic [DATA_W-1:0] rs1;
    logic [DATA_W-1:0] rs2;

    // Commit writes; port 2 overrides port 1 on the same address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i <= NREG; i++) begin
                if (rf.Rd2Addr == ADDR_W'(i)) begin
                    regs[i] <= rf.Rd2Data;
                end else if (rf.Rd1Addr == ADDR_W'(i)) begin
                    regs[i] <= rf.Rd1Data;
                end
            end
        end
    end

    // Read port 1 with write-first forwarding, zero during reset.
    always_comb begin
        rs1 = '0;
        if (rst_n && rf.Rs1Addr != '0) begin
            if (rf.Rs1Addr == rf.Rd2Addr) begin
                rs1 = rf.Rd2Data;
            end else if (rf.Rs1Addr == rf.Rd1Addr) begin
                rs1 = rf.Rd1Data;
            end else begin
                rs1 = regs[rf.Rs1Addr];
            end
        end
    end

    // Read port 2, identical rules to port 1.
    always_comb begin
        rs2 = '0;
        if (rst_n && rf.Rs2Addr != '0) begin
            if (rf.Rs2Addr == rf.Rd2Addr) begin
                rs2 = rf.Rd2Data;
            end else if (rf.Rs2Addr == rf.Rd1Addr) begin
                rs2 = rf.Rd1Data;
            end else begin
                rs2 = regs[rf.Rs2Addr];
            end
        end
    end

    assign rf.Rs1Data = rs1;
    assign rf.Rs2Data = rs2;
endmodule

// File: tb/tb_rv_regfile_drdw.sv
// Bench for rv_regfile_drdw: directed vector table, reset
// sequences and randomized traffic against an array model.
module tb_rv_regfile_drdw;
    logic clk;
    logic rst_n;

    rf_drdw_intf #(.addr_w(4), .data_w(32)) rf ();

    rv_regfile_drdw #(.ADDR_W(4), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rd1a;
        logic [31:0] rd1d;
        logic [3:0]  rd2a;
        logic [31:0] rd2d;
        logic [3:0]  rs1a;
        logic [3:0]  rs2a;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vec [11];
    logic [31:0] mem [16];
    int npass;
    int ntotal;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] mread(input logic [3:0] a);
        if (!rst_n || a == 4'd0) return 32'd0;
        if (a == rf.Rd2Addr) return rf.Rd2Data;
        if (a == rf.Rd1Addr) return rf.Rd1Data;
        return mem[a];
    endfunction

    task automatic drive(input logic [3:0] a1, input logic [31:0] d1,
                         input logic [3:0] a2, input logic [31:0] d2,
                         input logic [3:0] r1, input logic [3:0] r2);
        rf.Rd1Addr = a1;
        rf.Rd1Data = d1;
        rf.Rd2Addr = a2;
        rf.Rd2Data = d2;
        rf.Rs1Addr = r1;
        rf.Rs2Addr = r2;
    endtask

    // One clock edge; the model commits in program order, port 2 last.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (rf.Rd1Addr != 4'd0) mem[rf.Rd1Addr] = rf.Rd1Data;
            if (rf.Rd2Addr != 4'd0) mem[rf.Rd2Addr] = rf.Rd2Data;
        end
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    endtask

    initial begin
        npass = 0;
        ntotal = 0;
        model_reset();
        vec[0]  = '{4'd3, 32'hDEADBEEF, 4'd7, 32'h12345678,
                    4'd3, 4'd7, 32'hDEADBEEF, 32'h12345678};
        vec[1]  = '{4'd0, 32'h0, 4'd0, 32'h0,
                    4'd3, 4'd7, 32'hDEADBEEF, 32'h12345678};
        vec[2]  = '{4'd5, 32'h1111, 4'd5, 32'h2222,
                    4'd5, 4'd5, 32'h2222, 32'h2222};
        vec[3]  = '{4'd0, 32'h0, 4'd0, 32'h0,
                    4'd5, 4'd0, 32'h2222, 32'h0};
        vec[4]  = '{4'd0, 32'hFFFFFFFF, 4'd0, 32'h0,
                    4'd0, 4'd3, 32'h0, 32'hDEADBEEF};
        vec[5]  = '{4'd0, 32'h0, 4'd0, 32'h0,
                    4'd0, 4'd7, 32'h0, 32'h12345678};
        vec[6]  = '{4'd0, 32'h0, 4'd9, 32'hA5A5A5A5,
                    4'd1, 4'd15, 32'h0, 32'h0};
        vec[7]  = '{4'd9, 32'h5A5A5A5A, 4'd0, 32'h0,
                    4'd1, 4'd9, 32'h0, 32'h5A5A5A5A};
        vec[8]  = '{4'd9, 32'h1, 4'd9, 32'h2,
                    4'd9, 4'd5, 32'h2, 32'h2222};
        vec[9]  = '{4'd14, 32'hE, 4'd15, 32'hF,
                    4'd14, 4'd15, 32'hE, 32'hF};
        vec[10] = '{4'd0, 32'h0, 4'd0, 32'h0,
                    4'd9, 4'd14, 32'h2, 32'hE};

        // Reset sweep, with writes and matching reads driven.
        drive(4'd0, 32'h0, 4'd0, 32'h0, 4'd0, 4'd0);
        rst_n = 1'b0;
        #2;
        for (int a = 0; a < 16; a++) begin
            drive(4'(a), $urandom, 4'(a), $urandom, 4'(a), 4'(15 - a));
            #1;
            check("rst_rs1", rf.Rs1Data, 32'd0);
            check("rst_rs2", rf.Rs2Data, 32'd0);
        end
        tick();
        tick();
        drive(4'd0, 32'h0, 4'd0, 32'h0, 4'd0, 4'd0);
        #1;
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 16; a++) begin
            drive(4'd0, 32'h0, 4'd0, 32'h0, 4'(a), 4'(15 - a));
            #1;
            check("post_rst_rs1", rf.Rs1Data, 32'd0);
            check("post_rst_rs2", rf.Rs2Data, 32'd0);
        end

        // Directed vector table.
        for (int i = 0; i < 11; i++) begin
            drive(vec[i].rd1a, vec[i].rd1d, vec[i].rd2a, vec[i].rd2d,
                  vec[i].rs1a, vec[i].rs2a);
            #1;
            check($sformatf("vec%0d_rs1", i), rf.Rs1Data, vec[i].e1);
            check($sformatf("vec%0d_rs2", i), rf.Rs2Data, vec[i].e2);
            tick();
        end

        // Mid-cycle reset pulse wipes x4.
        drive(4'd4, 32'hCAFE, 4'd0, 32'h0, 4'd4, 4'd4);
        tick();
        drive(4'd0, 32'h0, 4'd0, 32'h0, 4'd4, 4'd9);
        #1;
        check("x4_stored", rf.Rs1Data, 32'hCAFE);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("x4_in_rst", rf.Rs1Data, 32'd0);
        rst_n = 1'b1;
        #1;
        check("x4_after_rst", rf.Rs1Data, 32'd0);
        check("x9_after_rst", rf.Rs2Data, 32'd0);
        tick();

        // Write under reset is lost; first edge after release commits.
        drive(4'd6, 32'h66, 4'd0, 32'h0, 4'd6, 4'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(4'd0, 32'h0, 4'd0, 32'h0, 4'd6, 4'd0);
        #1;
        check("wr_in_rst_lost", rf.Rs1Data, 32'd0);
        drive(4'd6, 32'h77, 4'd0, 32'h0, 4'd0, 4'd0);
        tick();
        drive(4'd0, 32'h0, 4'd0, 32'h0, 4'd6, 4'd0);
        #1;
        check("first_wr_after_rst", rf.Rs1Data, 32'h77);

        // Randomized traffic against the array model.
        for (int n = 0; n < 400; n++) begin
            logic [3:0] a1;
            logic [3:0] a2;
            logic [3:0] r1;
            logic [3:0] r2;
            a1 = 4'($urandom_range(0, 15));
            a2 = ($urandom_range(0, 3) == 0) ? a1
                 : 4'($urandom_range(0, 15));
            r1 = ($urandom_range(0, 2) == 0) ? a2
                 : 4'($urandom_range(0, 15));
            r2 = ($urandom_range(0, 2) == 0) ? a1
                 : 4'($urandom_range(0, 15));
            drive(a1, $urandom, a2, $urandom, r1, r2);
            #1;
            check("rand_rs1", rf.Rs1Data, mread(r1));
            check("rand_rs2", rf.Rs2Data, mread(r2));
            tick();
        end

        // Final sweep of stored contents with no writes.
        for (int a = 0; a < 16; a++) begin
            drive(4'd0, 32'h0, 4'd0, 32'h0, 4'(a), 4'(a));
            #1;
            check("final_rs1", rf.Rs1Data, mread(4'(a)));
            check("final_rs2", rf.Rs2Data, mread(4'(a)));
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
